// File: rtl/chroma_key_pixel_feeder_pkg.sv
// Colour format and keying defaults shared by the compositor and the VGA controller.
// Keeping them here lets both sides agree on word layout and the underflow marker colour.
package chroma_key_pixel_feeder_pkg;

    localparam int COLOR_W = 10;
    localparam int RGB_W   = 3 * COLOR_W;

    localparam logic [COLOR_W-1:0] DEF_KEY_MARGIN  = 10'd64;
    localparam logic [COLOR_W-1:0] DEF_KEY_G_MIN   = 10'd256;
    localparam logic [RGB_W-1:0]   DEF_UNDER_COLOR = 30'h3FF00000;

    // Green must clear both other channels by more than the margin; 11-bit sums never wrap.
    function automatic logic key_match(
        input logic [COLOR_W-1:0] r,
        input logic [COLOR_W-1:0] g,
        input logic [COLOR_W-1:0] b,
        input logic [COLOR_W-1:0] margin,
        input logic [COLOR_W-1:0] g_min
    );
        logic [COLOR_W:0] g_ext;
        logic [COLOR_W:0] r_lim;
        logic [COLOR_W:0] b_lim;
        g_ext = {1'b0, g};
        r_lim = {1'b0, r} + {1'b0, margin};
        b_lim = {1'b0, b} + {1'b0, margin};
        return (g >= g_min) && (g_ext > r_lim) && (g_ext > b_lim);
    endfunction

endpackage

// File: rtl/chroma_key_pixel_feeder_fifo_ram.sv
// Simple dual-port pixel store with a registered read port, written to map onto block RAM.
// No reset: contents are don't-care until written, and the top masks stale read data.
module chroma_fifo_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 30
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/chroma_key_pixel_feeder.sv
// Chroma-key compositor feeding the VGA controller: keys green-screen foreground against
// background at write time, buffers composited words, and pops one per request cycle.
module chroma_key_pixel_feeder
    import chroma_key_pixel_feeder_pkg::*;
#(
    parameter int                 ADDR_W      = 10,
    parameter logic [COLOR_W-1:0] KEY_MARGIN  = DEF_KEY_MARGIN,
    parameter logic [COLOR_W-1:0] KEY_G_MIN   = DEF_KEY_G_MIN,
    parameter logic [RGB_W-1:0]   UNDER_COLOR = DEF_UNDER_COLOR
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [COLOR_W-1:0] iFG_R,
    input  logic [COLOR_W-1:0] iFG_G,
    input  logic [COLOR_W-1:0] iFG_B,
    input  logic [COLOR_W-1:0] iBG_R,
    input  logic [COLOR_W-1:0] iBG_G,
    input  logic [COLOR_W-1:0] iBG_B,
    input  logic               iWR_VALID,
    output logic               oWR_READY,
    input  logic               iKeyEnable,
    input  logic               iFlush,
    input  logic               iRequest,
    output logic [COLOR_W-1:0] oRed,
    output logic [COLOR_W-1:0] oGreen,
    output logic [COLOR_W-1:0] oBlue,
    output logic [ADDR_W:0]    oLevel,
    output logic               oUnderflow
);

    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEVEL_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              alive_q;
    logic              rd_valid_q;
    logic              underflow_q;
    logic              underflow_sticky;
    logic [RGB_W-1:0]  rd_data;
    logic [RGB_W-1:0]  wr_word;
    logic              key;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              pop;
    logic              under;

    // Level never exceeds the depth, so its MSB alone marks full.
    assign full      = level[ADDR_W];
    assign empty     = (level == '0);
    assign oWR_READY = alive_q & ~full;

    assign key     = iKeyEnable & key_match(iFG_R, iFG_G, iFG_B, KEY_MARGIN, KEY_G_MIN);
    assign wr_word = key ? {iBG_R, iBG_G, iBG_B} : {iFG_R, iFG_G, iFG_B};

    assign wr_en = iWR_VALID & oWR_READY & ~iFlush;
    assign pop   = iRequest & ~empty & ~iFlush;
    assign under = iRequest & empty & ~iFlush;

    chroma_fifo_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RGB_W)
    ) u_ram (
        .clk     (iCLK),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            level            <= '0;
            alive_q          <= 1'b0;
            rd_valid_q       <= 1'b0;
            underflow_q      <= 1'b0;
            underflow_sticky <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (iFlush) begin
                wr_ptr           <= '0;
                rd_ptr           <= '0;
                level            <= '0;
                rd_valid_q       <= 1'b0;
                underflow_q      <= 1'b0;
                underflow_sticky <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                case ({wr_en, pop})
                    2'b10:   level <= level + LEVEL_ONE;
                    2'b01:   level <= level - LEVEL_ONE;
                    default: level <= level;
                endcase
                rd_valid_q  <= pop;
                underflow_q <= under;
                if (under) begin
                    underflow_sticky <= 1'b1;
                end
            end
        end
    end

    // Stale RAM output is hidden unless the previous cycle actually popped.
    assign {oRed, oGreen, oBlue} = rd_valid_q  ? rd_data     :
                                   underflow_q ? UNDER_COLOR : '0;
    assign oLevel     = level;
    assign oUnderflow = underflow_sticky;

endmodule
